// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the decode-stage hazard unit and its
//   neighbours (decode, regFile_bypass).
//   - entry_t   : one tracked in-flight instruction {valid, rd, regwrt, is_load}
//   - DEF_DEPTH : default number of tracked stages between decode and write-back
//   - DEF_NREG  : default architectural register count
//   - sat_inc16 : saturating 16-bit increment used by the stall counter
package hazard_pkg;

   localparam int unsigned DEF_DEPTH = 3;
   localparam int unsigned DEF_NREG  = 8;

   // Widest register index an entry can carry (register files up to 256 entries).
   // Narrower indices are zero-extended on capture and compare.
   localparam int unsigned REG_W_MAX = 8;

   typedef struct packed {
      logic                 valid;
      logic [REG_W_MAX-1:0] rd;
      logic                 regwrt;
      logic                 is_load;
   } entry_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/decode_hazard_unit_if.sv
// decode_hazard_unit_if
//   Decode-side bundle between the decoder (master) and the hazard unit (slave).
//   master drives : id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd,
//                   id_regwrt, id_is_load, flush
//   slave drives  : stall, bubble, wb_rd, wb_regwrt, stall_count, err
interface decode_hazard_unit_if
   import hazard_pkg::*;
#(
   parameter int unsigned NREG = DEF_NREG
);
   localparam int unsigned REG_W = $clog2(NREG);

   logic             id_valid;
   logic [REG_W-1:0] id_rs;
   logic             id_rs_used;
   logic [REG_W-1:0] id_rt;
   logic             id_rt_used;
   logic [REG_W-1:0] id_rd;
   logic             id_regwrt;
   logic             id_is_load;
   logic             flush;

   logic             stall;
   logic             bubble;
   logic [REG_W-1:0] wb_rd;
   logic             wb_regwrt;
   logic [15:0]      stall_count;
   logic             err;

   modport master (
      output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd,
             id_regwrt, id_is_load, flush,
      input  stall, bubble, wb_rd, wb_regwrt, stall_count, err
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd,
             id_regwrt, id_is_load, flush,
      output stall, bubble, wb_rd, wb_regwrt, stall_count, err
   );

endinterface

// File: rtl/hazard_cmp.sv
// hazard_cmp
//   Combinational writer match of one tracked entry against both decode sources.
//   ent        : tracked entry
//   rs/rs_used : source 1 index and read flag
//   rt/rt_used : source 2 index and read flag
//   match      : entry is a live writer of a source that decode reads
//   load_match : match where the writer is a load
module hazard_cmp
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W = 3
) (
   input  entry_t           ent,
   input  logic [REG_W-1:0] rs,
   input  logic             rs_used,
   input  logic [REG_W-1:0] rt,
   input  logic             rt_used,
   output logic             match,
   output logic             load_match
);

   logic rs_hit;
   logic rt_hit;

   always_comb begin
      rs_hit     = rs_used & (ent.rd == REG_W_MAX'(rs));
      rt_hit     = rt_used & (ent.rd == REG_W_MAX'(rt));
      match      = ent.valid & ent.regwrt & (rs_hit | rt_hit);
      load_match = match & ent.is_load;
   end

endmodule

// File: rtl/decode_hazard_unit.sv
// decode_hazard_unit
//   Destination-tracking pipeline and RAW-hazard detector for the decode stage.
//   Carries each decoded RD/RegWrt down DEPTH stages to the register-file write
//   port and requests a stall when a decode source is still being produced.
//   clk, rst_n : pipeline clock (rising edge), asynchronous active-low reset
//   bus        : decode bundle (slave side), see decode_hazard_unit_if
//   Parameters : DEPTH (2..8), NREG (power of two), FWD (0 none, 1 ALU fwd),
//                WDOG (consecutive stall cycles that raise err)
module decode_hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned NREG  = DEF_NREG,
   parameter int unsigned FWD   = 0,
   parameter int unsigned WDOG  = 2 * DEPTH
) (
   input logic                 clk,
   input logic                 rst_n,
   decode_hazard_unit_if.slave bus
);

   localparam int unsigned REG_W = $clog2(NREG);
   localparam int unsigned WD_W  = $clog2(WDOG + 1);

   // Without forwarding every stage but the write port can hazard (the
   // register-file bypass covers the write port). With ALU forwarding only a
   // load sitting in entry 0 can.
   localparam logic [DEPTH-1:0] NOFWD_MASK = {1'b0, {(DEPTH-1){1'b1}}};
   localparam logic [DEPTH-1:0] LOAD_MASK  = DEPTH'(1);

   entry_t            entry_q [DEPTH];
   entry_t            entry_d [DEPTH];
   logic [15:0]       stall_count_q, stall_count_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              err_q, err_d;

   logic [DEPTH-1:0]  match_w;
   logic [DEPTH-1:0]  load_w;
   logic              hazard;
   logic              stall;
   logic              bubble;

   for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
      hazard_cmp #(
         .REG_W (REG_W)
      ) u_cmp (
         .ent        (entry_q[i]),
         .rs         (bus.id_rs),
         .rs_used    (bus.id_rs_used),
         .rt         (bus.id_rt),
         .rt_used    (bus.id_rt_used),
         .match      (match_w[i]),
         .load_match (load_w[i])
      );
   end

   assign hazard = (FWD != 0) ? |(load_w & LOAD_MASK) : |(match_w & NOFWD_MASK);
   // A flushed instruction is dead, so it never needs to wait.
   assign stall  = bus.id_valid & ~bus.flush & hazard;
   assign bubble = stall | bus.flush | ~bus.id_valid;

   always_comb begin
      entry_d[0] = '0;
      if (!bubble) begin
         entry_d[0] = '{valid:   1'b1,
                        rd:      REG_W_MAX'(bus.id_rd),
                        regwrt:  bus.id_regwrt,
                        is_load: bus.id_is_load};
      end
      // Older instructions drain every cycle, stalled or not.
      for (int unsigned i = 1; i < DEPTH; i++) begin
         entry_d[i] = entry_q[i-1];
      end
   end

   always_comb begin
      stall_count_d = stall ? sat_inc16(stall_count_q) : stall_count_q;
      wdog_d        = '0;
      if (stall) begin
         wdog_d = (wdog_q == WD_W'(WDOG)) ? wdog_q : wdog_q + 1'b1;
      end
      err_d = err_q | (wdog_d == WD_W'(WDOG));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q       <= '{default: '0};
         stall_count_q <= '0;
         wdog_q        <= '0;
         err_q         <= 1'b0;
      end else begin
         entry_q       <= entry_d;
         stall_count_q <= stall_count_d;
         wdog_q        <= wdog_d;
         err_q         <= err_d;
      end
   end

   assign bus.stall       = stall;
   assign bus.bubble      = bubble;
   assign bus.wb_rd       = entry_q[DEPTH-1].rd[REG_W-1:0];
   assign bus.wb_regwrt   = entry_q[DEPTH-1].valid & entry_q[DEPTH-1].regwrt;
   assign bus.stall_count = stall_count_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// tb_decode_hazard_unit
//   Directed scoreboard bench for decode_hazard_unit. Three instances:
//   u0 default (DEPTH=3, FWD=0), u1 with ALU forwarding, u2 with DEPTH=2, WDOG=4.
//   Each driven cycle pushes its expected outputs; a negedge monitor pops and
//   compares against the selected instance.
module tb_decode_hazard_unit;

   typedef struct {
      int    d;
      int    es, eb, erd, erw, ecnt, eerr;
      string nm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [14:0] drv [3];
   logic [22:0] obs [3];
   exp_t        sb [$];
   exp_t        cur;
   logic [22:0] got;
   int          n_vec  = 0;
   int          n_miss = 0;

   always #5 clk = ~clk;

   decode_hazard_unit_if #(.NREG(8)) if0 ();
   decode_hazard_unit_if #(.NREG(8)) if1 ();
   decode_hazard_unit_if #(.NREG(8)) if2 ();

   decode_hazard_unit #(.DEPTH(3), .NREG(8), .FWD(0), .WDOG(6))
      u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   decode_hazard_unit #(.DEPTH(3), .NREG(8), .FWD(1), .WDOG(6))
      u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   decode_hazard_unit #(.DEPTH(2), .NREG(8), .FWD(0), .WDOG(4))
      u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   assign {if0.id_valid, if0.id_rs, if0.id_rs_used, if0.id_rt, if0.id_rt_used,
           if0.id_rd, if0.id_regwrt, if0.id_is_load, if0.flush} = drv[0];
   assign {if1.id_valid, if1.id_rs, if1.id_rs_used, if1.id_rt, if1.id_rt_used,
           if1.id_rd, if1.id_regwrt, if1.id_is_load, if1.flush} = drv[1];
   assign {if2.id_valid, if2.id_rs, if2.id_rs_used, if2.id_rt, if2.id_rt_used,
           if2.id_rd, if2.id_regwrt, if2.id_is_load, if2.flush} = drv[2];

   assign obs[0] = {if0.stall, if0.bubble, if0.wb_rd, if0.wb_regwrt, if0.stall_count, if0.err};
   assign obs[1] = {if1.stall, if1.bubble, if1.wb_rd, if1.wb_regwrt, if1.stall_count, if1.err};
   assign obs[2] = {if2.stall, if2.bubble, if2.wb_rd, if2.wb_regwrt, if2.stall_count, if2.err};

   // Drive one instance (others idle) and queue what it must show this cycle.
   task automatic drive_push(input int d, v, rs, rsu, rt, rtu, rd, rw, ld, fl,
                             input int es, eb, erd, erw, ecnt, eerr, input string nm);
      exp_t e;
      for (int k = 0; k < 3; k++) drv[k] = '0;
      drv[d] = {1'(v), 3'(rs), 1'(rsu), 3'(rt), 1'(rtu), 3'(rd), 1'(rw), 1'(ld), 1'(fl)};
      e = '{d, es, eb, erd, erw, ecnt, eerr, nm};
      sb.push_back(e);
   endtask

   task automatic apply(input int d, v, rs, rsu, rt, rtu, rd, rw, ld, fl,
                        input int es, eb, erd, erw, ecnt, eerr, input string nm);
      @(posedge clk);
      #1;
      drive_push(d, v, rs, rsu, rt, rtu, rd, rw, ld, fl, es, eb, erd, erw, ecnt, eerr, nm);
   endtask

   task automatic chk_idle(input int d, erd, erw, ecnt, eerr, input string nm);
      apply(d, 0,0,0,0,0, 0,0,0,0, 0,1, erd, erw, ecnt, eerr, nm);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) drv[k] = '0;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            got = obs[cur.d];
            n_vec++;
            if (int'(got[22]) != cur.es || int'(got[21]) != cur.eb ||
                int'(got[20:18]) != cur.erd || int'(got[17]) != cur.erw ||
                int'(got[16:1]) != cur.ecnt || int'(got[0]) != cur.eerr) begin
               n_miss++;
               $display("FAIL %s: got stall=%0d bubble=%0d wb_rd=%0d wb_regwrt=%0d cnt=%0h err=%0d, expected stall=%0d bubble=%0d wb_rd=%0d wb_regwrt=%0d cnt=%0h err=%0d",
                        cur.nm, got[22], got[21], got[20:18], got[17], got[16:1], got[0],
                        cur.es, cur.eb, cur.erd, cur.erw, cur.ecnt, cur.eerr);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) drv[k] = '0;

      // Reset state of each instance.
      chk_idle(0, 0, 0, 0, 0, "rst_u0");
      chk_idle(1, 0, 0, 0, 0, "rst_u1");
      chk_idle(2, 0, 0, 0, 0, "rst_u2");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // Writer of R2 then back-to-back reader: 2 stall cycles, release as R2 hits wb.
      apply(0, 1,0,0,0,0, 2,1,0,0, 0,0, 0,0, 0,0, "t1_writer");
      apply(0, 1,2,1,0,0, 5,1,0,0, 1,1, 0,0, 0,0, "t1_stall1");
      apply(0, 1,2,1,0,0, 5,1,0,0, 1,1, 0,0, 1,0, "t1_stall2");
      apply(0, 1,2,1,0,0, 5,1,0,0, 0,0, 2,1, 2,0, "t1_release");
      chk_idle(0, 0, 0, 2, 0, "t1_drain0");
      chk_idle(0, 0, 0, 2, 0, "t1_drain1");
      chk_idle(0, 5, 1, 2, 0, "t1_wb_reader");
      idle(3);

      // Hazard coinciding with flush: no stall, bubble, entry 0 left empty.
      apply(0, 1,0,0,0,0, 4,1,0,0, 0,0, 0,0, 2,0, "fl_writer");
      apply(0, 1,4,1,0,0, 6,1,0,1, 0,1, 0,0, 2,0, "fl_hazard_flush");
      apply(0, 1,6,1,0,0, 7,0,0,0, 0,0, 0,0, 2,0, "fl_e0_empty");
      chk_idle(0, 4, 1, 2, 0, "fl_wb_writer");
      idle(3);

      // 20 independent instructions: writers R4..R7, readers R0..R3.
      for (int i = 0; i < 20; i++) begin
         apply(0, 1, i % 4, 1, (i + 1) % 4, 1, 4 + i % 4, 1, 0, 0,
               0, 0, (i >= 3) ? 4 + (i - 3) % 4 : 0, (i >= 3) ? 1 : 0, 2, 0,
               $sformatf("str_%0d", i));
      end
      for (int j = 20; j < 23; j++) begin
         chk_idle(0, 4 + (j - 3) % 4, 1, 2, 0, $sformatf("str_tail_%0d", j));
      end
      idle(3);

      // ALU forwarding: load-use stalls one cycle, ALU-use does not.
      apply(1, 1,0,0,0,0, 3,1,1,0, 0,0, 0,0, 0,0, "fw_load");
      apply(1, 1,3,1,0,0, 1,1,0,0, 1,1, 0,0, 0,0, "fw_load_use");
      apply(1, 1,3,1,0,0, 1,1,0,0, 0,0, 0,0, 1,0, "fw_release");
      apply(1, 1,0,0,0,0, 3,1,0,0, 0,0, 3,1, 1,0, "fw_alu_writer");
      apply(1, 1,0,0,3,1, 2,1,0,0, 0,0, 0,0, 1,0, "fw_alu_use");
      idle(3);

      // Watchdog and counter saturation on the DEPTH=2 instance.
      @(posedge clk);
      #1;
      force u2.stall_count_q = 16'hFFFE;
      force u2.hazard = 1'b1;
      #1;
      release u2.stall_count_q;
      apply(2, 1,1,1,1,1, 1,1,0,0, 1,1, 0,0, 'hFFFE,0, "wd_s1");
      apply(2, 1,1,1,1,1, 1,1,0,0, 1,1, 0,0, 'hFFFF,0, "wd_s2");
      apply(2, 1,1,1,1,1, 1,1,0,0, 1,1, 0,0, 'hFFFF,0, "wd_s3");
      apply(2, 1,1,1,1,1, 1,1,0,0, 1,1, 0,0, 'hFFFF,0, "wd_s4");
      apply(2, 1,1,1,1,1, 1,1,0,0, 1,1, 0,0, 'hFFFF,1, "wd_s5_err");
      apply(2, 1,1,1,1,1, 1,1,0,0, 1,1, 0,0, 'hFFFF,1, "wd_s6_err");
      @(posedge clk);
      #1;
      release u2.hazard;
      drive_push(2, 0,0,0,0,0, 0,0,0,0, 0,1, 0,0, 'hFFFF,1, "wd_sticky0");
      apply(2, 1,0,0,0,0, 6,1,0,0, 0,0, 0,0, 'hFFFF,1, "wd_normal");
      chk_idle(2, 0, 0, 'hFFFF, 1, "wd_lat0");
      chk_idle(2, 6, 1, 'hFFFF, 1, "wd_lat_wb");
      idle(3);

      // Asynchronous reset in the middle of a stall, then normal flow.
      apply(0, 1,0,0,0,0, 2,1,0,0, 0,0, 0,0, 2,0, "rs_writer");
      apply(0, 1,2,1,0,0, 5,1,0,0, 1,1, 0,0, 2,0, "rs_stall");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive_push(0, 1,2,1,0,0, 5,1,0,0, 0,0, 0,0, 0,0, "rs_async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_push(0, 1,2,1,0,0, 5,1,0,0, 0,0, 0,0, 0,0, "rs_resume");
      chk_idle(0, 0, 0, 0, 0, "rs_drain0");
      chk_idle(0, 0, 0, 0, 0, "rs_drain1");
      chk_idle(0, 5, 1, 0, 0, "rs_wb_reader");
      chk_idle(2, 0, 0, 0, 0, "rs_u2_cleared");

      @(posedge clk);
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d unchecked vectors, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/decode_hazard_unit.md
# decode_hazard_unit

Parametrised destination-tracking and RAW-hazard unit for the decode stage of the 16-bit MIPS-style pipeline. It owns the delayed destination-register/write-enable pipeline that carries each decoded instruction's RD and RegWrt down to the register-file write port. It compares the current decode sources against all in-flight writers and produces a stall/bubble request, supporting a no-forwarding mode and an ALU-forwarding mode. It also keeps a stall counter and a stall watchdog for debug.

## Interface
Parameters:
- DEPTH, 3: number of tracked stages between decode and write-back, legal 2..8; entry DEPTH-1 drives the write port.
- NREG, 8: architectural register count, power of two.
- REG_W, $clog2(NREG): register index width, derived; never overridden.
- FWD, 0: 0 means no forwarding; 1 means ALU forwarding exists and only load-use hazards stall.
- WDOG, 2*DEPTH: consecutive stall cycles that raise `err`.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  REG_W  source 1 index, instr[10:8].
- id_rs_used  in  1  source 1 is read.
- id_rt  in  REG_W  source 2 index, instr[7:5].
- id_rt_used  in  1  source 2 is read.
- id_rd  in  REG_W  resolved destination after RegDst muxing.
- id_regwrt  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a memory read.
- flush  in  1  kill the decode instruction (taken branch/jump).
- stall  out  1  hold fetch/decode this cycle; combinational.
- bubble  out  1  a NOP enters stage 0 at the next edge (stall | flush | ~id_valid).
- wb_rd  out  REG_W  write-port register, entry[DEPTH-1].rd.
- wb_regwrt  out  1  write-port enable, entry[DEPTH-1].valid & .regwrt.
- stall_count  out  16  saturating count of stalled cycles.
- err  out  1  watchdog flag, sticky until reset.

## Operation
- State: entry[0..DEPTH-1], each holding {valid, rd, regwrt, is_load}. entry[0] is the youngest.
- The shift is unconditional every edge: entry[i] <= entry[i-1]. Older instructions keep draining during a stall.
- entry[0] capture:
  - If bubble = 1, entry[0] <= all zero.
  - Otherwise entry[0] <= {1, id_rd, id_regwrt, id_is_load}.
- Writer match, for stage i and source s: entry[i].valid & entry[i].regwrt & (entry[i].rd == s) & s_used.
- Hazard with FWD=0: a match on either source in entries 0..DEPTH-2. Entry DEPTH-1 is excluded because the register-file bypass forwards the same-cycle write.
- Hazard with FWD=1: a match in entry[0] with entry[0].is_load set.
- stall = id_valid & ~flush & hazard.
  - flush overrides stall, because the killed instruction has no hazard.
- stall_count increments on every cycle with stall = 1 and saturates at 16'hFFFF.
- Watchdog counter:
  - Increments each consecutive stall cycle and clears on any non-stall cycle.
  - Sets err when it reaches WDOG. err stays set until reset.
  - A legal program never stalls more than DEPTH-1 consecutive cycles.

## Timing
- Reset (asynchronous assert, synchronous-edge release): all entries invalid, stall_count = 0, watchdog = 0, err = 0.
  - Consequences: wb_regwrt = 0 and stall = 0 unless the inputs force it. bubble = 1 while id_valid = 0.
- Instruction latency: accepted at edge k, it drives wb_rd/wb_regwrt between edges k+DEPTH-1 and k+DEPTH.
- Worst-case FWD=0 stall: a dependent instruction right behind a writer stalls DEPTH-1 cycles. It proceeds in the cycle the writer occupies entry[DEPTH-1].
- FWD=1 load-use: exactly 1 stall cycle.
- Simultaneous flush and hazard: stall = 0 and bubble = 1.
- stall_count at 16'hFFFF holds its value on further stalls.
- Reset asserted mid-stall: stall drops as entries clear. No partial state survives.

## Structure
- Shared package `hazard_pkg` holds:
  - the entry struct typedef {valid, rd, regwrt, is_load};
  - the default DEPTH/NREG constants shared with decode and regFile_bypass.
- One natural sub-module: `hazard_cmp`. It is combinational, compares one entry against both sources, and is instantiated DEPTH times.
- The shift pipeline, counters and watchdog stay in the top module.

## Test plan
Default parameters unless noted (DEPTH=3, FWD=0).
- Writer then dependent back-to-back (R2<=…, then a read of R2): stall=1 for exactly 2 cycles, then 0. wb_rd=2 with wb_regwrt=1 during the release cycle.
- FWD=1, load to R3 then a read of R3: one stall cycle. An ALU writer to R3 followed by a read of R3 gives no stall.
- Hazard with flush=1 in the same cycle: stall=0 and bubble=1. entry[0] is invalid on the next cycle.
- Independent stream of 20 instructions (disjoint registers): stall never asserts. wb_rd sequence equals the input id_rd sequence delayed by 3 edges.
- Force id_valid with a permanent match by holding entries through a bench-forced bypass (DEPTH=2, WDOG=4): err rises after the 4th consecutive stall cycle and stays high. stall_count saturates when preloaded to 16'hFFFE.
- rst_n asserted during a stall: all outputs return to reset values asynchronously. Normal flow resumes after release.
